// File: rtl/ahb_mtx_rr_arb_if.sv
// Output-port bus bundle for the round-robin matrix arbiter.
// The slave modport is the arbiter's view; master is the driving side.
interface ahb_mtx_rr_arb_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 3
);
  logic [NUM_PORTS-1:0] req;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic                 no_port;
  logic                 burst_hold;

  modport slave (
    input  req, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port, burst_hold
  );

  modport master (
    output req, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port, burst_hold
  );
endinterface

// File: rtl/ahb_mtx_rr_arb.sv
// Round-robin output-stage arbiter for one AHB matrix slave port.
// Ownership is frozen during fixed-length bursts and locked sequences.
module ahb_mtx_rr_arb #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 3
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_mtx_rr_arb_if.slave bus
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  logic [3:0]           r_cnt;
  logic                 r_hold;
  logic [PORT_W-1:0]    r_addr_in_port;
  logic                 r_no_port;

  htrans_e              w_trans;
  logic [3:0]           w_cnt_nxt;
  logic                 w_hold_nxt;
  logic                 w_cur_act;
  logic [NUM_PORTS-1:0] w_eff;
  logic                 w_hi_found;
  logic                 w_lo_found;
  logic [PORT_W-1:0]    w_hi_pick;
  logic [PORT_W-1:0]    w_lo_pick;
  logic [PORT_W-1:0]    w_addr_nxt;
  logic                 w_no_port_nxt;

  assign w_trans   = htrans_e'(bus.HTRANSM);
  assign w_cur_act = bus.HSELM & (w_trans != TR_IDLE);

  // Beats remaining in a fixed-length burst; hold stays set until the last SEQ.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_hold_nxt = r_hold;
    if (bus.HREADYM) begin
      if (!bus.HSELM) begin
        w_cnt_nxt  = 4'd0;
        w_hold_nxt = 1'b0;
      end else begin
        unique case (w_trans)
          TR_NONSEQ: begin
            unique case (bus.HBURSTM)
              3'b110, 3'b111: begin w_cnt_nxt = 4'd15; w_hold_nxt = 1'b1; end
              3'b100, 3'b101: begin w_cnt_nxt = 4'd7;  w_hold_nxt = 1'b1; end
              3'b010, 3'b011: begin w_cnt_nxt = 4'd3;  w_hold_nxt = 1'b1; end
              default:        begin w_cnt_nxt = 4'd0;  w_hold_nxt = 1'b0; end
            endcase
          end
          TR_SEQ: begin
            if (r_cnt == 4'd0) begin
              w_cnt_nxt  = 4'd0;
              w_hold_nxt = 1'b0;
            end else begin
              w_cnt_nxt  = r_cnt - 4'd1;
              w_hold_nxt = (r_cnt == 4'd1) ? 1'b0 : r_hold;
            end
          end
          TR_BUSY: begin
            w_cnt_nxt  = r_cnt;
            w_hold_nxt = r_hold;
          end
          default: begin
            w_cnt_nxt  = 4'd0;
            w_hold_nxt = 1'b0;
          end
        endcase
      end
    end
  end

  // Round-robin search: first requester above the current owner, else wrap from 0.
  always_comb begin
    w_eff      = bus.req;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_pick  = r_addr_in_port;
    w_lo_pick  = r_addr_in_port;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PORT_W'(i) == r_addr_in_port) begin
        w_eff[i] = bus.req[i] | w_cur_act;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_eff[i] && (PORT_W'(i) > r_addr_in_port) && !w_hi_found) begin
        w_hi_found = 1'b1;
        w_hi_pick  = PORT_W'(i);
      end
      if (w_eff[i] && (PORT_W'(i) <= r_addr_in_port) && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo_pick  = PORT_W'(i);
      end
    end
  end

  // Lock or a live burst (using next-cycle hold) pins the current owner.
  always_comb begin
    w_addr_nxt    = r_addr_in_port;
    w_no_port_nxt = 1'b0;
    if (bus.HMASTLOCKM || w_hold_nxt) begin
      w_addr_nxt = r_addr_in_port;
    end else if (w_hi_found) begin
      w_addr_nxt = w_hi_pick;
    end else if (w_lo_found) begin
      w_addr_nxt = w_lo_pick;
    end else if (bus.HSELM) begin
      w_addr_nxt = r_addr_in_port;
    end else begin
      w_no_port_nxt = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt          <= 4'd0;
      r_hold         <= 1'b0;
      r_addr_in_port <= '0;
      r_no_port      <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_hold <= w_hold_nxt;
      if (bus.HREADYM) begin
        r_addr_in_port <= w_addr_nxt;
        r_no_port      <= w_no_port_nxt;
      end
    end
  end

  assign bus.addr_in_port = r_addr_in_port;
  assign bus.no_port      = r_no_port;
  assign bus.burst_hold   = r_hold;

endmodule

// File: tb/tb_ahb_mtx_rr_arb.sv
// Directed bench for the round-robin AHB output-stage arbiter.
// Each task drives one scenario and checks hand-computed grants inline.
module tb_ahb_mtx_rr_arb;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101, INCR16 = 3'b111;

  logic HCLK;
  logic HRESETn;
  int   n_cmp;
  int   n_err;

  ahb_mtx_rr_arb_if #(.NUM_PORTS(4), .PORT_W(3)) bus ();

  ahb_mtx_rr_arb #(.NUM_PORTS(4), .PORT_W(3)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic sel, input logic [1:0] tr,
                               input logic [2:0] bu, input logic lk, input logic rdy);
    bus.req        = r;
    bus.HSELM      = sel;
    bus.HTRANSM    = tr;
    bus.HBURSTM    = bu;
    bus.HMASTLOCKM = lk;
    bus.HREADYM    = rdy;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    applyStimulus(4'b0000, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    #12;
    n_cmp++;
    if (bus.addr_in_port !== 3'd0) begin
      n_err++; $display("[TB] FAIL reset_addr got %0d want 0", bus.addr_in_port);
    end
    n_cmp++;
    if (bus.no_port !== 1'b1) begin
      n_err++; $display("[TB] FAIL reset_no_port got %b want 1", bus.no_port);
    end
    n_cmp++;
    if (bus.burst_hold !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_hold got %b want 0", bus.burst_hold);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_round_robin();
    int exp_a[5] = '{1, 2, 3, 0, 1};
    applyStimulus(4'b1111, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.addr_in_port !== 3'(exp_a[i])) begin
        n_err++; $display("[TB] FAIL rr_addr[%0d] got %0d want %0d", i, bus.addr_in_port, exp_a[i]);
      end
      n_cmp++;
      if (bus.no_port !== 1'b0) begin
        n_err++; $display("[TB] FAIL rr_no_port[%0d] got %b want 0", i, bus.no_port);
      end
    end
  endtask

  task automatic test_burst_incr4();
    int   exp_a[4] = '{2, 2, 2, 0};
    logic exp_h[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    applyStimulus(4'b0100, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (bus.addr_in_port !== 3'd2) begin
      n_err++; $display("[TB] FAIL incr4_setup got %0d want 2", bus.addr_in_port);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0011, 1'b1, (i == 0) ? NONSEQ : SEQ, INCR4, 1'b0, 1'b1);
      tick();
      n_cmp++;
      if (bus.addr_in_port !== 3'(exp_a[i]) || bus.burst_hold !== exp_h[i]) begin
        n_err++;
        $display("[TB] FAIL incr4_beat[%0d] got addr=%0d hold=%b want addr=%0d hold=%b",
                 i, bus.addr_in_port, bus.burst_hold, exp_a[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_ready_stall();
    applyStimulus(4'b0010, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (bus.addr_in_port !== 3'd1) begin
      n_err++; $display("[TB] FAIL stall_setup got %0d want 1", bus.addr_in_port);
    end
    // NONSEQ, 3 SEQ, 3 stalled cycles, then 4 more SEQ; only the final SEQ releases.
    for (int i = 0; i < 11; i++) begin
      logic       rdy;
      logic [1:0] tr;
      logic [2:0] ea;
      logic       eh;
      rdy = !(i >= 4 && i <= 6);
      tr  = (i == 0) ? NONSEQ : SEQ;
      ea  = (i == 10) ? 3'd0 : 3'd1;
      eh  = (i == 10) ? 1'b0 : 1'b1;
      applyStimulus(4'b0001, 1'b1, tr, INCR8, 1'b0, rdy);
      tick();
      n_cmp++;
      if (bus.addr_in_port !== ea || bus.burst_hold !== eh) begin
        n_err++;
        $display("[TB] FAIL stall_step[%0d] got addr=%0d hold=%b want addr=%0d hold=%b",
                 i, bus.addr_in_port, bus.burst_hold, ea, eh);
      end
    end
  endtask

  task automatic test_lock();
    applyStimulus(4'b1000, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (bus.addr_in_port !== 3'd3) begin
      n_err++; $display("[TB] FAIL lock_setup got %0d want 3", bus.addr_in_port);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0111, 1'b1, NONSEQ, SINGLE, 1'b1, 1'b1);
      tick();
      n_cmp++;
      if (bus.addr_in_port !== 3'd3 || bus.burst_hold !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL lock_hold[%0d] got addr=%0d hold=%b want addr=3 hold=0",
                 i, bus.addr_in_port, bus.burst_hold);
      end
    end
    applyStimulus(4'b0111, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (bus.addr_in_port !== 3'd0) begin
      n_err++; $display("[TB] FAIL lock_release got %0d want 0", bus.addr_in_port);
    end
  endtask

  task automatic test_no_request();
    applyStimulus(4'b0010, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (bus.no_port !== 1'b1 || bus.addr_in_port !== 3'd1) begin
      n_err++;
      $display("[TB] FAIL idle_none got addr=%0d no_port=%b want addr=1 no_port=1",
               bus.addr_in_port, bus.no_port);
    end
    applyStimulus(4'b0000, 1'b1, IDLE, SINGLE, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (bus.no_port !== 1'b0 || bus.addr_in_port !== 3'd1) begin
      n_err++;
      $display("[TB] FAIL idle_selected got addr=%0d no_port=%b want addr=1 no_port=0",
               bus.addr_in_port, bus.no_port);
    end
    applyStimulus(4'b0100, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (bus.no_port !== 1'b0 || bus.addr_in_port !== 3'd2) begin
      n_err++;
      $display("[TB] FAIL idle_to_req got addr=%0d no_port=%b want addr=2 no_port=0",
               bus.addr_in_port, bus.no_port);
    end
  endtask

  task automatic test_busy_deselect();
    logic [1:0] tr[3] = '{NONSEQ, BUSY, BUSY};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0001, 1'b1, tr[i], INCR4, 1'b0, 1'b1);
      tick();
      n_cmp++;
      if (bus.addr_in_port !== 3'd2 || bus.burst_hold !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL busy_hold[%0d] got addr=%0d hold=%b want addr=2 hold=1",
                 i, bus.addr_in_port, bus.burst_hold);
      end
    end
    applyStimulus(4'b0001, 1'b0, IDLE, INCR4, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (bus.addr_in_port !== 3'd0 || bus.burst_hold !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL deselect_release got addr=%0d hold=%b want addr=0 hold=0",
               bus.addr_in_port, bus.burst_hold);
    end
  endtask

  task automatic test_reset_mid_burst();
    applyStimulus(4'b0100, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    tick();
    applyStimulus(4'b1111, 1'b1, NONSEQ, INCR16, 1'b0, 1'b1);
    tick();
    applyStimulus(4'b1111, 1'b1, SEQ, INCR16, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (bus.addr_in_port !== 3'd2 || bus.burst_hold !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL incr16_mid got addr=%0d hold=%b want addr=2 hold=1",
               bus.addr_in_port, bus.burst_hold);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    n_cmp++;
    if (bus.addr_in_port !== 3'd0 || bus.no_port !== 1'b1 || bus.burst_hold !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL async_reset got addr=%0d no_port=%b hold=%b want addr=0 no_port=1 hold=0",
               bus.addr_in_port, bus.no_port, bus.burst_hold);
    end
    applyStimulus(4'b1111, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
    n_cmp++;
    if (bus.addr_in_port !== 3'd1 || bus.no_port !== 1'b0 || bus.burst_hold !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL post_reset_grant got addr=%0d no_port=%b hold=%b want addr=1 no_port=0 hold=0",
               bus.addr_in_port, bus.no_port, bus.burst_hold);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_round_robin();
    test_burst_incr4();
    test_ready_stall();
    test_lock();
    test_no_request();
    test_busy_deselect();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
